// File: rtl/riscv_mmio_initiator.sv
// Queued single-transfer AHB-Lite initiator for MMIO requests: in-order responses,
// pipelined address/data phases, local rejection of oversized or misaligned requests.
module riscv_mmio_initiator #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,

   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [HADDR_SIZE-1:0] req_addr,
   input  logic [2:0]            req_size,
   input  logic [HDATA_SIZE-1:0] req_wdata,

   output logic                  rsp_valid,
   output logic [HDATA_SIZE-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,

   output logic [1:0]            HTRANS,
   output logic [HADDR_SIZE-1:0] HADDR,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [HDATA_SIZE-1:0] HWDATA,
   input  logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int MAX_SIZE = $clog2(HDATA_SIZE / 8);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef struct packed {
      logic                  write;
      logic [HADDR_SIZE-1:0] addr;
      logic [2:0]            size;
      logic [HDATA_SIZE-1:0] wdata;
   } req_t;

   req_t                  fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      head_reg;
   logic [PTR_W-1:0]      tail_reg;
   logic [PTR_W:0]        count_reg;

   logic                  dp_valid_reg;
   logic                  dp_write_reg;
   logic [HDATA_SIZE-1:0] dp_wdata_reg;

   logic                  rsp_valid_reg;
   logic                  rsp_err_reg;
   logic [HDATA_SIZE-1:0] rsp_rdata_reg;

   req_t                  head;
   logic                  queue_nonempty;
   logic [6:0]            align_mask;
   logic                  head_lerr;
   logic                  err_cancel;
   logic                  issue;
   logic                  lerr_pop;
   logic                  push;
   logic                  pop;

   assign head           = fifo_mem[head_reg];
   assign queue_nonempty = (count_reg != '0);
   assign req_ready      = (count_reg != (PTR_W+1)'(FIFO_DEPTH));

   assign align_mask = (7'd1 << head.size) - 7'd1;
   assign head_lerr  = (head.size > 3'(MAX_SIZE)) || ((head.addr[6:0] & align_mask) != 7'd0);

   // An ERROR response on the outstanding transfer cancels any pending address phase.
   assign err_cancel = dp_valid_reg && HRESP;
   assign issue      = queue_nonempty && !err_cancel && !head_lerr;
   assign lerr_pop   = queue_nonempty && head_lerr && !dp_valid_reg;

   assign push = req_valid && req_ready;
   assign pop  = (issue && HREADY) || lerr_pop;

   assign HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR  = issue ? head.addr  : '0;
   assign HWRITE = issue ? head.write : 1'b0;
   assign HSIZE  = issue ? head.size  : 3'b000;
   assign HBURST = 3'b000;
   assign HPROT  = 4'b0011;
   assign HWDATA = (dp_valid_reg && dp_write_reg) ? dp_wdata_reg : '0;

   assign rsp_valid = rsp_valid_reg;
   assign rsp_err   = rsp_err_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign busy      = queue_nonempty || dp_valid_reg || rsp_valid_reg;

   // Queue storage carries no reset; occupancy is tracked solely by count_reg.
   always_ff @(posedge HCLK) begin
      if (push) begin
         fifo_mem[tail_reg] <= '{write: req_write, addr: req_addr, size: req_size, wdata: req_wdata};
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         dp_valid_reg  <= 1'b0;
         dp_write_reg  <= 1'b0;
         dp_wdata_reg  <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         if (push) begin
            tail_reg <= tail_reg + PTR_W'(1);
         end
         if (pop) begin
            head_reg <= head_reg + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase

         if (HREADY) begin
            dp_valid_reg <= issue;
            if (issue) begin
               dp_write_reg <= head.write;
               dp_wdata_reg <= head.wdata;
            end
         end

         // A local error pop only happens with no data phase outstanding, so it never collides.
         if (dp_valid_reg && HREADY) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= HRESP;
            rsp_rdata_reg <= (!dp_write_reg && !HRESP) ? HRDATA : '0;
         end else if (lerr_pop) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= '0;
         end else begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
         end
      end
   end

endmodule

// File: doc/riscv_mmio_initiator.md
RISCV_MMIO_INITIATOR -- requirements
Module: riscv_mmio_initiator
Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32: AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32: AHB data width (32 or 64).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: request queue entries (power of two, >=2).
REQ-004 SHALL have port HCLK  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  queue can accept request.
REQ-008 SHALL have port req_write  input  1  1=write, 0=read.
REQ-009 SHALL have port req_addr  input  HADDR_SIZE  byte address.
REQ-010 SHALL have port req_size  input  3  AHB HSIZE encoding.
REQ-011 SHALL have port req_wdata  input  HDATA_SIZE  write data, lane-aligned.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response strobe, no backpressure.
REQ-013 SHALL have port rsp_rdata  output  HDATA_SIZE  read data (0 for writes and errors).
REQ-014 SHALL have port rsp_err  output  1  transfer ended in error.
REQ-015 SHALL have port busy  output  1  queue non-empty or data phase outstanding.
REQ-016 SHALL have port HTRANS  output  2  IDLE or NONSEQ only.
REQ-017 SHALL have port HADDR  output  HADDR_SIZE  transfer address.
REQ-018 SHALL have port HWRITE  output  1  transfer direction.
REQ-019 SHALL have port HSIZE  output  3  transfer size.
REQ-020 SHALL have port HBURST  output  3  constant SINGLE (3'b000).
REQ-021 SHALL have port HPROT  output  4  constant 4'b0011.
REQ-022 SHALL have port HWDATA  output  HDATA_SIZE  write data during data phase.
REQ-023 SHALL have port HRDATA  input  HDATA_SIZE  read data from responder.
REQ-024 SHALL have port HREADY  input  1  transfer-complete / bus-ready.
REQ-025 SHALL have port HRESP  input  1  0=OKAY, 1=ERROR.
Function
REQ-026 SHALL push on req_valid&&req_ready; req_ready = queue not full (no pass-through when full, even if popping same cycle).
REQ-027 SHALL drive address phase (HTRANS=NONSEQ, HADDR/HWRITE/HSIZE from queue head) combinationally whenever queue non-empty, not in error-cancel, and no local error on head; else HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0.
REQ-028 SHALL pop head and register it as the outstanding data phase on an edge where HTRANS=NONSEQ and HREADY=1; address-phase outputs SHALL stay stable while HREADY=0.
REQ-029 SHALL pipeline: next address phase may be issued during current data phase (back-to-back NONSEQ, one transfer per HREADY cycle).
REQ-030 SHALL drive HWDATA from registered write data throughout a write data phase, holding it until HREADY=1; HWDATA=0 otherwise.
REQ-031 SHALL complete a data phase on edge with HREADY=1; next cycle rsp_valid=1 for exactly one cycle, rsp_rdata=sampled HRDATA (reads, OKAY) else 0, rsp_err=sampled HRESP.
REQ-032 Latency: push at edge T into empty idle block with HREADY=1 -> NONSEQ in cycle T..T+1, data phase T+1..T+2, rsp_valid in cycle T+2..T+3.
REQ-033 Error: in data-phase cycle with HRESP=1, HREADY=0, HTRANS SHALL be IDLE; any head not yet accepted stays queued; HTRANS stays IDLE through the HREADY=1 error cycle; reissue from following cycle.
REQ-034 Local error: head with req_size > log2(HDATA_SIZE/8) or req_addr not aligned to 2^req_size SHALL be popped with no bus transfer, in order after outstanding data phase, giving rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-035 Responses SHALL return strictly in request order; at most one rsp_valid per cycle.
REQ-036 busy SHALL be 1 iff queue non-empty, data phase outstanding, or rsp pending.
Reset
REQ-037 On HRESETn low, asynchronously: queue empty, req_ready=1, HTRANS=IDLE, HADDR/HWRITE/HSIZE/HWDATA=0, HBURST=0, HPROT=4'b0011, rsp_valid/rsp_rdata/rsp_err=0, busy=0.
REQ-038 Reset mid-transfer SHALL abandon all queued and outstanding transfers without a response; first NONSEQ no earlier than first edge after deassertion with a new push.
Verification
REQ-039 Single write 0x80001000 data 0x1, HREADY=1 -> NONSEQ one cycle, HWDATA=0x1 next cycle, rsp_valid two edges after push, rsp_err=0.
REQ-040 Four reads pushed back-to-back, HREADY=1 -> four consecutive NONSEQ cycles, four rsp_valid pulses in order with matching HRDATA.
REQ-041 HREADY=0 for 3 cycles during write data phase -> HWDATA and pipelined HADDR held stable, rsp_valid after HREADY=1.
REQ-042 Two-cycle ERROR on first of two queued writes -> HTRANS=IDLE both error cycles, rsp_err=1 then second write reissued, rsp_err=0.
REQ-043 Push HDATA_SIZE=32 request size=3'b010 addr 0x80001082 -> no NONSEQ, rsp_err=1, rsp_rdata=0; FIFO_DEPTH+1 pushes with HREADY=0 -> req_ready=0 after FIFO_DEPTH.
REQ-044 Assert HRESETn low during HREADY=0 wait state -> outputs at reset values immediately, no rsp_valid afterwards.
